// File: rtl/fft_host.sv
// fft_host: gathers 8 complex samples, hands them to an external 8-point FFT,
// waits for its results and streams the 8 bins back out over valid/ready.
module fft_host #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_real,
  input  logic [W-1:0] s_imag,
  output logic         fft_write,
  output logic         fft_start,
  output logic [W-1:0] fft_in0_real,
  output logic [W-1:0] fft_in0_imag,
  output logic [W-1:0] fft_in1_real,
  output logic [W-1:0] fft_in1_imag,
  output logic [W-1:0] fft_in2_real,
  output logic [W-1:0] fft_in2_imag,
  output logic [W-1:0] fft_in3_real,
  output logic [W-1:0] fft_in3_imag,
  output logic [W-1:0] fft_in4_real,
  output logic [W-1:0] fft_in4_imag,
  output logic [W-1:0] fft_in5_real,
  output logic [W-1:0] fft_in5_imag,
  output logic [W-1:0] fft_in6_real,
  output logic [W-1:0] fft_in6_imag,
  output logic [W-1:0] fft_in7_real,
  output logic [W-1:0] fft_in7_imag,
  input  logic         fft_ready,
  input  logic [W-1:0] fft_out0_real,
  input  logic [W-1:0] fft_out0_imag,
  input  logic [W-1:0] fft_out1_real,
  input  logic [W-1:0] fft_out1_imag,
  input  logic [W-1:0] fft_out2_real,
  input  logic [W-1:0] fft_out2_imag,
  input  logic [W-1:0] fft_out3_real,
  input  logic [W-1:0] fft_out3_imag,
  input  logic [W-1:0] fft_out4_real,
  input  logic [W-1:0] fft_out4_imag,
  input  logic [W-1:0] fft_out5_real,
  input  logic [W-1:0] fft_out5_imag,
  input  logic [W-1:0] fft_out6_real,
  input  logic [W-1:0] fft_out6_imag,
  input  logic [W-1:0] fft_out7_real,
  input  logic [W-1:0] fft_out7_imag,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_real,
  output logic [W-1:0] m_imag,
  output logic [2:0]   m_index,
  output logic         m_last,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_LOAD, S_WRITE, S_START, S_WAIT, S_DRAIN
  } state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic        live_q;

  logic [W-1:0] in_re_q  [8];
  logic [W-1:0] in_im_q  [8];
  logic [W-1:0] res_re_q [8];
  logic [W-1:0] res_im_q [8];
  logic [W-1:0] out_re   [8];
  logic [W-1:0] out_im   [8];

  logic s_acc, m_acc, cap, tmo;

  assign out_re = '{fft_out0_real, fft_out1_real,
                    fft_out2_real, fft_out3_real,
                    fft_out4_real, fft_out5_real,
                    fft_out6_real, fft_out7_real};
  assign out_im = '{fft_out0_imag, fft_out1_imag,
                    fft_out2_imag, fft_out3_imag,
                    fft_out4_imag, fft_out5_imag,
                    fft_out6_imag, fft_out7_imag};

  assign s_acc = s_valid && s_ready;
  assign m_acc = m_valid && m_ready;
  // first WAIT cycle (timer 0) ignores a ready left over from a prior run
  assign cap   = (state_q == S_WAIT) && fft_ready
              && (timer_q != 16'd0);
  assign tmo   = (state_q == S_WAIT) && !cap
              && (timer_q == TLAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (s_acc && cnt_q == 3'd7) state_d = S_WRITE;
      S_WRITE: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (cap)      state_d = S_DRAIN;
        else if (tmo) state_d = S_LOAD;
      end
      S_DRAIN: if (m_acc && idx_q == 3'd7) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    fft_write = 1'b0;
    fft_start = 1'b0;
    m_valid   = 1'b0;
    unique case (state_q)
      S_LOAD:  s_ready = live_q;
      S_WRITE: fft_write = 1'b1;
      S_START: begin
        fft_write = 1'b1;
        fft_start = 1'b1;
      end
      S_WAIT:  fft_write = 1'b1;
      S_DRAIN: m_valid = 1'b1;
      default: ;
    endcase
  end

  // counters wrap naturally: 8th beat/bin brings cnt/idx back to 0
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    timer_d = '0;
    if (s_acc) cnt_d = cnt_q + 3'd1;
    if (m_acc) idx_d = idx_q + 3'd1;
    if (state_q == S_WAIT) timer_d = timer_q + 16'd1;
    if (tmo) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 8; k++) begin
        in_re_q[k]  <= '0;
        in_im_q[k]  <= '0;
        res_re_q[k] <= '0;
        res_im_q[k] <= '0;
      end
    end else begin
      if (s_acc) begin
        in_re_q[cnt_q] <= s_real;
        in_im_q[cnt_q] <= s_imag;
      end
      if (cap) begin
        for (int k = 0; k < 8; k++) begin
          res_re_q[k] <= out_re[k];
          res_im_q[k] <= out_im[k];
        end
      end
    end
  end

  assign fft_in0_real = in_re_q[0];
  assign fft_in0_imag = in_im_q[0];
  assign fft_in1_real = in_re_q[1];
  assign fft_in1_imag = in_im_q[1];
  assign fft_in2_real = in_re_q[2];
  assign fft_in2_imag = in_im_q[2];
  assign fft_in3_real = in_re_q[3];
  assign fft_in3_imag = in_im_q[3];
  assign fft_in4_real = in_re_q[4];
  assign fft_in4_imag = in_im_q[4];
  assign fft_in5_real = in_re_q[5];
  assign fft_in5_imag = in_im_q[5];
  assign fft_in6_real = in_re_q[6];
  assign fft_in6_imag = in_im_q[6];
  assign fft_in7_real = in_re_q[7];
  assign fft_in7_imag = in_im_q[7];

  assign m_real      = res_re_q[idx_q];
  assign m_imag      = res_im_q[idx_q];
  assign m_index     = idx_q;
  assign m_last      = (idx_q == 3'd7);
  assign busy        = !((state_q == S_LOAD) && (cnt_q == 3'd0));
  assign timeout_err = err_q;

endmodule

// File: tb/tb_fft_host.sv
// tb_fft_host: vector table plus scoreboard bench for fft_host,
// with a behavioural FFT responder and directed timeout/reset sequences.
module tb_fft_host;

  localparam int W  = 16;
  localparam int TO = 20;

  typedef struct packed {
    logic [7:0][W-1:0] re;
    logic [7:0][W-1:0] im;
    logic [7:0][W-1:0] xr;
    logic [7:0][W-1:0] xi;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [2:0]   idx;
  } exp_t;

  logic              CLK, RST;
  logic              s_valid, s_ready;
  logic [W-1:0]      s_real, s_imag;
  logic              fft_write, fft_start, fft_ready;
  wire  [7:0][W-1:0] fi_re, fi_im;
  logic [7:0][W-1:0] fo_re, fo_im;
  logic              m_valid, m_ready, m_last, busy, timeout_err;
  logic [W-1:0]      m_real, m_imag;
  logic [2:0]        m_index;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t tbl[4];

  fft_host #(.W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag),
    .fft_write(fft_write), .fft_start(fft_start),
    .fft_in0_real(fi_re[0]), .fft_in0_imag(fi_im[0]),
    .fft_in1_real(fi_re[1]), .fft_in1_imag(fi_im[1]),
    .fft_in2_real(fi_re[2]), .fft_in2_imag(fi_im[2]),
    .fft_in3_real(fi_re[3]), .fft_in3_imag(fi_im[3]),
    .fft_in4_real(fi_re[4]), .fft_in4_imag(fi_im[4]),
    .fft_in5_real(fi_re[5]), .fft_in5_imag(fi_im[5]),
    .fft_in6_real(fi_re[6]), .fft_in6_imag(fi_im[6]),
    .fft_in7_real(fi_re[7]), .fft_in7_imag(fi_im[7]),
    .fft_ready(fft_ready),
    .fft_out0_real(fo_re[0]), .fft_out0_imag(fo_im[0]),
    .fft_out1_real(fo_re[1]), .fft_out1_imag(fo_im[1]),
    .fft_out2_real(fo_re[2]), .fft_out2_imag(fo_im[2]),
    .fft_out3_real(fo_re[3]), .fft_out3_imag(fo_im[3]),
    .fft_out4_real(fo_re[4]), .fft_out4_imag(fo_im[4]),
    .fft_out5_real(fo_re[5]), .fft_out5_imag(fo_im[5]),
    .fft_out6_real(fo_re[6]), .fft_out6_imag(fo_im[6]),
    .fft_out7_real(fo_re[7]), .fft_out7_imag(fo_im[7]),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < 8; k++) begin
      v.re[k] = W'($urandom);
      v.im[k] = W'($urandom);
      v.xr[k] = W'($urandom);
      v.xi[k] = W'($urandom);
    end
    return v;
  endfunction

  // feeds 8 beats, then walks WRITE/START/first WAIT cycle
  task automatic load_start(input vec_t v, input bit gaps,
                            input bit stale);
    int i = 0;
    int g = 0;
    while (i < 8 && g < 100) begin
      @(negedge CLK);
      g++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_real  = W'($urandom);
      end else begin
        check("load_rdy", {s_ready, fft_write}, 2'b10);
        s_valid = 1'b1;
        s_real  = v.re[i];
        s_imag  = v.im[i];
        i++;
      end
    end
    if (i < 8) check("load_to", 0, 1);
    if (stale) begin
      fft_ready = 1'b1;
      fo_re = ~v.xr;
      fo_im = ~v.xi;
    end
    @(negedge CLK);
    s_valid = 1'b0;
    check("write_st", {s_ready, fft_write, fft_start, busy},
          4'b0101);
    check("in_re", fi_re, v.re);
    check("in_im", fi_im, v.im);
    @(negedge CLK);
    check("start_st", {fft_write, fft_start, m_valid}, 3'b110);
    @(negedge CLK);
    check("wait1_st", {fft_write, fft_start, m_valid}, 3'b100);
    check("in_hold", fi_re, v.re);
    if (stale) begin
      @(negedge CLK);
      check("stale_nocap", m_valid, 0);
      fft_ready = 1'b0;
    end
  endtask

  // FFT model: raises ready with results after dly cycles
  task automatic respond(input vec_t v, input int dly);
    exp_t e;
    repeat (dly) @(negedge CLK);
    fft_ready = 1'b1;
    fo_re = v.xr;
    fo_im = v.xi;
    for (int k = 0; k < 8; k++) begin
      e.re  = v.xr[k];
      e.im  = v.xi[k];
      e.idx = 3'(k);
      q.push_back(e);
    end
    @(negedge CLK);
    fft_ready = 1'b0;
    fo_re = ~v.xr;
    fo_im = ~v.xi;
    check("cap_lat", m_valid, 1);
  endtask

  task automatic drain(input bit bp, input int stop);
    int beats = 0;
    int g = 0;
    bit held = 0;
    exp_t h, e;
    while (beats < 8 && g < 400) begin
      g++;
      if (m_valid) begin
        if (held)
          check("stall_hold", {m_real, m_imag, m_index}, h);
        if (stop >= 0 && int'(m_index) == stop) return;
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_ready) begin
          held = 0;
          if (q.size() == 0) begin
            check("sb_empty", 1, 0);
          end else begin
            e = q.pop_front();
            check("bin", {m_real, m_imag, m_index, m_last},
                  {e, e.idx == 3'd7});
          end
          beats++;
        end else begin
          held = 1;
          h = {m_real, m_imag, m_index};
        end
      end else begin
        m_ready = 1'b0;
      end
      @(negedge CLK);
    end
    m_ready = 1'b0;
    if (beats < 8) check("drain_to", beats, 8);
    check("drain_end", {m_valid, s_ready, busy}, 3'b010);
  endtask

  initial begin
    vec_t v;
    bit   bad;
    RST = 1'b1;
    s_valid = 1'b0;
    s_real = '0;
    s_imag = '0;
    fft_ready = 1'b0;
    fo_re = '0;
    fo_im = '0;
    m_ready = 1'b0;

    tbl[0].re = '0;
    tbl[0].im = '0;
    for (int k = 0; k < 8; k++) tbl[0].re[k] = W'(k << 8);
    tbl[0].xr = {8{16'hFC00}};
    tbl[0].xr[0] = 16'h1C00;
    tbl[0].xi = {16'hF658, 16'hFC00, 16'hFE58, 16'h0000,
                 16'h01A8, 16'h0400, 16'h09A8, 16'h0000};
    tbl[1] = rnd_vec();
    tbl[2].re = {4{16'h8000, 16'h7FFF}};
    tbl[2].im = {4{16'hFFFF, 16'h0001}};
    tbl[2].xr = {8{16'h7FFF}};
    tbl[2].xi = {8{16'h8000}};
    tbl[3] = rnd_vec();

    repeat (2) @(negedge CLK);
    check("rst_ctl", {s_ready, fft_write, fft_start, m_valid,
          busy, timeout_err, m_last, m_index}, 0);
    check("rst_in", fi_re, 0);
    check("rst_m", {m_real, m_imag}, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("rel_rdy", {s_ready, busy}, 2'b10);

    for (int i = 0; i < 4; i++) begin
      load_start(tbl[i], i[0], i == 2);
      respond(tbl[i], (i == 2) ? 3 : 4);
      drain(0, -1);
    end

    // ready arrives on the very last WAIT cycle: capture wins
    load_start(tbl[1], 0, 0);
    respond(tbl[1], TO - 1);
    check("tie_err", timeout_err, 0);
    drain(1, -1);

    load_start(tbl[3], 0, 0);
    bad = 0;
    repeat (TO - 1) begin
      @(negedge CLK);
      if (m_valid) bad = 1;
    end
    check("to_pre", {timeout_err, s_ready, bad}, 0);
    @(negedge CLK);
    check("to_set", {timeout_err, s_ready, m_valid}, 3'b110);
    load_start(tbl[0], 1, 0);
    respond(tbl[0], 4);
    drain(1, -1);
    check("to_sticky", timeout_err, 1);

    for (int r = 0; r < 100; r++) begin
      v = rnd_vec();
      load_start(v, 1, 0);
      respond(v, 1 + $urandom_range(0, 4));
      drain(1, -1);
    end

    load_start(tbl[0], 0, 0);
    respond(tbl[0], 4);
    drain(0, 3);
    RST = 1'b1;
    #1;
    check("rmid_ctl", {s_ready, fft_write, fft_start, m_valid,
          busy, timeout_err, m_last, m_index}, 0);
    check("rmid_in", {fi_re, fi_im}, 0);
    check("rmid_m", {m_real, m_imag}, 0);
    m_ready = 1'b0;
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rmid_rel", {s_ready, m_valid, busy}, 3'b100);
    load_start(tbl[2], 0, 0);
    respond(tbl[2], 4);
    drain(0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_host.md
FFT_HOST -- requirements
Module: fft_host

Interface
REQ-001 SHALL have parameter W, default 16: sample width, signed Q8.8 two's complement.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum WAIT cycles before abort, range 2..65535.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  in  1  input sample valid.
REQ-006 SHALL have port s_ready  out  1  host can accept an input sample.
REQ-007 SHALL have port s_real  in  W  input sample, real part.
REQ-008 SHALL have port s_imag  in  W  input sample, imaginary part.
REQ-009 SHALL have port fft_write  out  1  FFT input-load enable.
REQ-010 SHALL have port fft_start  out  1  FFT start pulse.
REQ-011 SHALL have ports fft_inK_real and fft_inK_imag, K=0..7  out  W each  registered FFT operands.
REQ-012 SHALL have port fft_ready  in  1  FFT results valid.
REQ-013 SHALL have ports fft_outK_real and fft_outK_imag, K=0..7  in  W each  FFT results.
REQ-014 SHALL have port m_valid  out  1  output sample valid.
REQ-015 SHALL have port m_ready  in  1  downstream accepts an output sample.
REQ-016 SHALL have ports m_real and m_imag  out  W each  output bin.
REQ-017 SHALL have port m_index  out  3  bin number of the current output.
REQ-018 SHALL have port m_last  out  1  high when m_index==7.
REQ-019 SHALL have port busy  out  1  high whenever the FSM is not in LOAD with slot count 0.
REQ-020 SHALL have port timeout_err  out  1  sticky abort flag.

Function
REQ-021 SHALL implement the FSM states LOAD, WRITE, START, WAIT and DRAIN.
REQ-022 LOAD SHALL drive s_ready=1; every s_valid&&s_ready beat SHALL store into slot cnt (0..7), then cnt SHALL increment; gaps in s_valid SHALL neither advance cnt nor reorder slots.
REQ-023 Acceptance of the 8th beat SHALL move the FSM to WRITE on the next edge and reset cnt to 0; s_ready SHALL be 0 in every state other than LOAD.
REQ-024 fft_inK_* SHALL be driven directly from the slot registers and SHALL stay stable from WRITE until the FSM next returns to LOAD.
REQ-025 fft_write SHALL be 1 in WRITE, START and WAIT, and 0 otherwise.
REQ-026 fft_start SHALL be 1 for exactly the single START cycle, which SHALL directly follow the single WRITE cycle.
REQ-027 In WAIT, fft_ready SHALL be ignored on the first WAIT cycle, so that a stale ready from the previous run is not captured.
REQ-028 From the second WAIT cycle, fft_ready==1 SHALL capture all 16 fft_out* values into the result registers in one edge and move the FSM to DRAIN.
REQ-029 The WAIT timer SHALL count from 0 on WAIT entry; on reaching TIMEOUT-1 without capture, timeout_err SHALL be set, the data SHALL be discarded and the FSM SHALL go to LOAD.
REQ-030 If capture and timeout occur in the same cycle, capture SHALL win and timeout_err SHALL not be set.
REQ-031 DRAIN SHALL drive m_valid=1 and present m_real, m_imag and m_index from the result register idx, starting at idx=0.
REQ-032 A m_valid&&m_ready beat SHALL increment idx; the handshake at idx 7 SHALL return the FSM to LOAD with m_valid=0 on the next cycle.
REQ-033 While m_valid=1 and m_ready=0, all m_* outputs SHALL hold stable.
REQ-034 Latency from 8th input accept edge: WRITE SHALL be entered +1 cycle, START +2, WAIT +3.
REQ-035 Minimum latency from capture edge to first m_valid SHALL be 0 cycles, i.e. m_valid is high in the cycle after the capture edge.
REQ-036 The block SHALL pass data through with no arithmetic; the W-bit values SHALL be moved unmodified.
REQ-037 timeout_err SHALL clear only on RST.

Reset
REQ-038 While RST=1, asynchronously: state=LOAD, cnt=idx=timer=0, all slot and result registers=0, and every output=0 (including s_ready).
REQ-039 s_ready SHALL rise to 1 in the first cycle after RST deasserts; RST asserted mid-operation SHALL abort the transaction with no partial output after release.

Verification
REQ-040 Load real ramp 0x0000,0x0100..0x0700 with imag=0 -> fft_in0..7_real equal the ramp; fft_write rises 1 cycle after the 8th accept; fft_start pulses exactly 1 cycle, 2 cycles after the 8th accept.
REQ-041 FFT model asserts fft_ready 5 cycles after start with ramp DFT values (X0=0x1C00+j0, X4=0xFC00+j0) and m_ready=1 -> 8 beats with m_index 0..7, X0 and X4 exact, m_last only on beat 7, FSM in LOAD afterwards.
REQ-042 Random m_ready backpressure over 100 runs -> m_* stable while stalled, no lost or duplicated bins, order 0..7 preserved.
REQ-043 fft_ready held 0 -> timeout_err=1 exactly TIMEOUT cycles after WAIT entry, s_ready=1 the next cycle, no m_valid; the next run completes normally with timeout_err still 1.
REQ-044 fft_ready=1 stale during WRITE, START and the first WAIT cycle -> no capture; capture occurs only on the second WAIT cycle or later.
REQ-045 RST pulse mid-DRAIN at idx 3 -> all outputs 0 immediately; after release a full 8-sample run completes with correct data.
